// File: rtl/stoch_signed_decode.sv
// Integrates a signed stochastic stream (x_p - x_m) over windows of 2**WINDOW_LOG2
// enabled cycles and presents the signed window sum with a one-cycle valid pulse.
module stoch_signed_decode #(
    parameter  int WINDOW_LOG2 = 8,
    localparam int OUT_WIDTH   = WINDOW_LOG2 + 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        en,
    input  logic                        clear,
    input  logic                        x_p,
    input  logic                        x_m,
    output logic signed [OUT_WIDTH-1:0] value,
    output logic                        valid
);

    localparam logic [WINDOW_LOG2-1:0] WIN_LAST = '1;

    logic signed [OUT_WIDTH-1:0] acc;
    logic signed [OUT_WIDTH-1:0] acc_next;
    logic        [WINDOW_LOG2-1:0] win_cnt;

    // Both channels high (or both low) cancel to zero.
    function automatic logic signed [OUT_WIDTH-1:0] delta_of(input logic p, input logic m);
        logic signed [OUT_WIDTH-1:0] d;
        d = '0;
        if (p && !m)
            d = {{(OUT_WIDTH-1){1'b0}}, 1'b1};
        else if (m && !p)
            d = '1;
        return d;
    endfunction

    assign acc_next = acc + delta_of(x_p, x_m);

    // Accumulate stage; the close edge folds in the final sample before publishing.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc     <= '0;
            win_cnt <= '0;
            value   <= '0;
            valid   <= 1'b0;
        end else if (clear) begin
            acc     <= '0;
            win_cnt <= '0;
            valid   <= 1'b0;
        end else if (!en) begin
            valid   <= 1'b0;
        end else if (win_cnt == WIN_LAST) begin
            value   <= acc_next;
            acc     <= '0;
            win_cnt <= '0;
            valid   <= 1'b1;
        end else begin
            acc     <= acc_next;
            win_cnt <= win_cnt + 1'b1;
            valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stoch_signed_decode.sv
// Bench for stoch_signed_decode: window-pattern table, clear/reset corner sequences,
// and randomized traffic against a sample-list reference model.
module tb_stoch_signed_decode;

    localparam int WL   = 8;
    localparam int N    = 1 << WL;
    localparam int OW   = WL + 2;
    localparam int NVEC = 5;

    logic                 CLK;
    logic                 RST;
    logic                 en;
    logic                 clear;
    logic                 x_p;
    logic                 x_m;
    logic signed [OW-1:0] value;
    logic                 valid;

    int tests = 0;
    int fails = 0;

    // Reference model: list of deltas in the current window, last published sum.
    int samples[$];
    int exp_value = 0;
    int exp_valid = 0;

    typedef struct {
        string name;
        int    xp_mode;   // 0: constant 0, 1: constant 1, 2: toggle 1,0,1,0...
        int    xm_mode;
        bit    en_alt;    // en alternates 1,0,1,0... when set
        int    exp_value;
        int    exp_cycles;
    } vec_t;

    vec_t vecs[NVEC];

    stoch_signed_decode #(.WINDOW_LOG2(WL)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .en    (en),
        .clear (clear),
        .x_p   (x_p),
        .x_m   (x_m),
        .value (value),
        .valid (valid)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic bit mode_bit(input int mode, input int c);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return (c % 2) == 1;
    endfunction

    function automatic int window_sum();
        int s = 0;
        foreach (samples[k]) s += samples[k];
        return s;
    endfunction

    // Drive one cycle's inputs, update the model at the edge, compare at the negedge.
    task automatic step(input bit e, input bit c, input bit p, input bit m);
        en    = e;
        clear = c;
        x_p   = p;
        x_m   = m;
        @(posedge CLK);
        exp_valid = 0;
        if (c) begin
            samples.delete();
        end else if (e) begin
            samples.push_back(int'(p) - int'(m));
            if (samples.size() == N) begin
                exp_value = window_sum();
                exp_valid = 1;
                samples.delete();
            end
        end
        @(negedge CLK);
        check("valid", int'(valid), exp_valid);
        check("value", int'(value), exp_value);
    endtask

    initial begin
        int cyc;
        bit got;

        vecs[0] = '{"T1 all plus",     1, 0, 1'b0,  256, 256};
        vecs[1] = '{"T2 all minus",    0, 1, 1'b0, -256, 256};
        vecs[2] = '{"T2 both high",    1, 1, 1'b0,    0, 256};
        vecs[3] = '{"T3 half plus",    2, 0, 1'b0,  128, 256};
        vecs[4] = '{"T4 en alternate", 1, 0, 1'b1,  256, 511};

        RST = 1'b1; en = 1'b0; clear = 1'b0; x_p = 1'b0; x_m = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset valid", int'(valid), 0);
        check("reset value", int'(value), 0);
        RST = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            cyc = 0;
            got = 1'b0;
            for (int c = 1; c <= 600 && !got; c++) begin
                step(vecs[i].en_alt ? ((c % 2) == 1) : 1'b1, 1'b0,
                     mode_bit(vecs[i].xp_mode, c), mode_bit(vecs[i].xm_mode, c));
                cyc = c;
                got = valid;
            end
            check({vecs[i].name, " cycles"}, got ? cyc : -1, vecs[i].exp_cycles);
            check({vecs[i].name, " value"}, int'(value), vecs[i].exp_value);
        end

        // T3 period: a second toggle window closes exactly 256 cycles later.
        got = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 300 && !got; c++) begin
            step(1'b1, 1'b0, mode_bit(2, c), 1'b0);
            cyc = c;
            got = valid;
        end
        check("T3 period", got ? cyc : -1, 256);
        check("T3 second value", int'(value), 128);

        // T5: clear on the would-be close cycle suppresses the window.
        for (int c = 0; c < N - 1; c++) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("T5 clear valid", int'(valid), 0);
        check("T5 clear held value", int'(value), 128);
        got = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 300 && !got; c++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            cyc = c;
            got = valid;
        end
        check("T5 fresh cycles", got ? cyc : -1, 256);
        check("T5 fresh value", int'(value), -256);

        // T6: asynchronous reset mid-window, away from any clock edge.
        for (int c = 0; c < 100; c++) step(1'b1, 1'b0, 1'b1, 1'b0);
        #2 RST = 1'b1;
        #1;
        check("T6 async value", int'(value), 0);
        check("T6 async valid", int'(valid), 0);
        samples.delete();
        exp_value = 0;
        exp_valid = 0;
        #1 RST = 1'b0;
        got = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 300 && !got; c++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            cyc = c;
            got = valid;
        end
        check("T6 restart cycles", got ? cyc : -1, 256);
        check("T6 restart value", int'(value), 256);

        // Randomized traffic: mostly enabled, rare clears, arbitrary channel bits.
        for (int c = 0; c < 4000; c++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 799) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
